// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, arbiter state
// encoding and the width of the watchdog revocation counter.
package uart_pkg;

   localparam int BYTE_W      = 8;
   localparam int STALL_CNT_W = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and uart_tx handshake bundle shared by the arbiter and its users.
// master drives the source side and the uart_tx acknowledge; slave is the arbiter.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int N_SRC = 4
);

   logic [BYTE_W*N_SRC-1:0] src_data;
   logic [N_SRC-1:0]        src_require;
   logic [N_SRC-1:0]        src_last;
   logic [N_SRC-1:0]        src_valid;
   logic [BYTE_W-1:0]       tx_data;
   logic                    tx_require;
   logic                    tx_valid;

   modport master (
      output src_data, src_require, src_last, tx_valid,
      input  src_valid, tx_data, tx_require
   );

   modport slave (
      input  src_data, src_require, src_last, tx_valid,
      output src_valid, tx_data, tx_require
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational cyclic priority encoder: returns the first set request at or
// after ptr, wrapping from N-1 back to 0.
module rr_pick #(
   parameter  int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         found
);

   // Scan from the farthest offset down so the nearest hit is written last.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int off = N - 1; off >= 0; off--) begin
         if (req[(int'(ptr) + off) % N]) begin
            idx   = W'((int'(ptr) + off) % N);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one uart_tx between N_SRC byte
// sources, with a watchdog that reclaims the transmitter from a stalled owner.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int N_SRC         = 4,
   parameter  int STALL_TIMEOUT = 50_000_000,
   localparam int GW            = $clog2(N_SRC),
   localparam int TW            = $clog2(STALL_TIMEOUT + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   uart_tx_arbiter_if.slave       bus,
   output logic [GW-1:0]          grant,
   output logic                   busy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   arb_state_t             state_reg, state_next;
   logic [GW-1:0]          grant_reg, grant_next;
   logic [GW-1:0]          rr_ptr_reg, rr_ptr_next;
   logic [TW-1:0]          stall_timer_reg, stall_timer_next;
   logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

   logic [BYTE_W-1:0]      src_bytes [N_SRC];
   logic [GW-1:0]          pick_idx;
   logic                   pick_found;
   logic                   owner_req;
   logic                   owner_last;
   logic                   xfer;
   logic                   timeout;

   function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] i);
      return (i == GW'(N_SRC - 1)) ? '0 : i + 1'b1;
   endfunction

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_bytes
      assign src_bytes[gi] = bus.src_data[BYTE_W*gi +: BYTE_W];
   end

   rr_pick #(
      .N (N_SRC)
   ) u_pick (
      .req   (bus.src_require),
      .ptr   (rr_ptr_reg),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign owner_req  = bus.src_require[grant_reg];
   assign owner_last = bus.src_last[grant_reg];
   assign xfer       = (state_reg == SERVE) && owner_req && bus.tx_valid;
   // The owner's require being low is the only thing that ages the watchdog.
   assign timeout    = (state_reg == SERVE) && !owner_req &&
                       (stall_timer_reg == TW'(STALL_TIMEOUT - 1));

   always_comb begin
      state_next       = state_reg;
      grant_next       = grant_reg;
      rr_ptr_next      = rr_ptr_reg;
      stall_timer_next = stall_timer_reg;
      stall_cnt_next   = stall_cnt_reg;
      bus.tx_require   = 1'b0;
      bus.tx_data      = '0;
      bus.src_valid    = '0;

      case (state_reg)
         IDLE: begin
            stall_timer_next = '0;
            if (pick_found) begin
               grant_next = pick_idx;
               state_next = SERVE;
            end
         end
         SERVE: begin
            bus.tx_require = owner_req;
            bus.tx_data    = src_bytes[grant_reg];
            bus.src_valid[grant_reg] = bus.tx_valid;
            stall_timer_next = owner_req ? '0 : stall_timer_reg + 1'b1;
            if (xfer && owner_last) begin
               rr_ptr_next      = next_idx(grant_reg);
               stall_timer_next = '0;
               state_next       = IDLE;
            end else if (timeout) begin
               rr_ptr_next      = next_idx(grant_reg);
               stall_timer_next = '0;
               stall_cnt_next   = (stall_cnt_reg == '1) ? stall_cnt_reg
                                                        : stall_cnt_reg + 1'b1;
               state_next       = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         grant_reg       <= '0;
         rr_ptr_reg      <= '0;
         stall_timer_reg <= '0;
         stall_cnt_reg   <= '0;
      end else begin
         state_reg       <= state_next;
         grant_reg       <= grant_next;
         rr_ptr_reg      <= rr_ptr_next;
         stall_timer_reg <= stall_timer_next;
         stall_cnt_reg   <= stall_cnt_next;
      end
   end

   assign grant     = grant_reg;
   assign busy      = (state_reg == SERVE);
   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: source queues feed bytes, expected transfers are queued in
// grant order and checked as the uart_tx model accepts them.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N   = 4;
   localparam int TMO = 20;

   typedef struct packed {
      logic [2:0] src;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  grant;
   logic        busy;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_SRC(N)) bus ();

   uart_tx_arbiter #(
      .N_SRC         (N),
      .STALL_TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .grant     (grant),
      .busy      (busy),
      .stall_cnt (stall_cnt)
   );

   int         vectors = 0;
   int         miscompares = 0;
   logic [8:0] src_q [N][$];
   exp_t       exp_q [$];
   logic [N-1:0] acc = '0;
   int         cyc = 0;
   int         xfer_cnt = 0;
   int         xfer_cyc = 0;
   int         ack_gap = 1;
   int         ucnt = 0;
   logic       uart_en = 1'b1;
   logic       tx_force = 1'b0;
   logic       prev_last = 1'b0;
   logic       prev_idle_req = 1'b0;

   assign bus.tx_valid = tx_force | (uart_en & bus.tx_require & (ucnt >= ack_gap - 1));

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Source drivers: present the queue head, pop it after an acknowledge.
   initial begin
      bus.src_require = '0;
      bus.src_last    = '0;
      bus.src_data    = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (rst_n && acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (rst_n && src_q[i].size() > 0) begin
               bus.src_require[i]      = 1'b1;
               bus.src_last[i]         = src_q[i][0][8];
               bus.src_data[8*i +: 8]  = src_q[i][0][7:0];
            end else begin
               bus.src_require[i] = 1'b0;
               bus.src_last[i]    = 1'b0;
            end
         end
      end
   end

   // uart_tx model: acknowledge after ack_gap cycles of tx_require.
   initial begin
      logic s_req, s_ack;
      forever begin
         @(negedge clk);
         s_req = bus.tx_require;
         s_ack = bus.tx_require & bus.tx_valid;
         @(posedge clk);
         #1;
         if (!rst_n || s_ack) ucnt = 0;
         else if (s_req) ucnt = ucnt + 1;
      end
   end

   // Monitor: scoreboard pops on every transfer plus per-cycle protocol checks.
   initial begin
      exp_t       e;
      logic [N-1:0] exp_sv;
      logic       is_xfer;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc = '0;
            prev_last = 1'b0;
            prev_idle_req = 1'b0;
         end else begin
            acc = bus.src_valid;
            is_xfer = (bus.tx_require === 1'b1) && (bus.tx_valid === 1'b1);
            if (prev_last) begin
               vectors++;
               if (busy !== 1'b0) begin
                  miscompares++;
                  $display("FAIL turnaround: busy=%b after last byte, required 0", busy);
               end
            end
            if (prev_idle_req) begin
               vectors++;
               if (busy !== 1'b1 || bus.tx_require !== 1'b1) begin
                  miscompares++;
                  $display("FAIL arb_latency: busy=%b tx_require=%b, required 1/1", busy, bus.tx_require);
               end
            end
            vectors++;
            if ((!is_xfer && bus.src_valid !== '0) || (busy === 1'b0 && bus.tx_require !== 1'b0)) begin
               miscompares++;
               $display("FAIL idle_outputs: busy=%b src_valid=%b tx_require=%b, required no ack/require",
                        busy, bus.src_valid, bus.tx_require);
            end
            if (is_xfer) begin
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_xfer: grant=%0d data=%h, required none", grant, bus.tx_data);
               end else begin
                  e = exp_q.pop_front();
                  exp_sv = '0;
                  exp_sv[e.src] = 1'b1;
                  if (grant !== e.src[1:0] || bus.tx_data !== e.data || bus.src_valid !== exp_sv) begin
                     miscompares++;
                     $display("FAIL xfer: grant=%0d data=%h src_valid=%b, required grant=%0d data=%h src_valid=%b",
                              grant, bus.tx_data, bus.src_valid, e.src, e.data, exp_sv);
                  end
               end
               xfer_cnt++;
               xfer_cyc = cyc;
            end
            prev_last = is_xfer && (bus.src_last[grant] === 1'b1);
            prev_idle_req = (busy === 1'b0) && (|bus.src_require);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic send(input int s, input logic [7:0] d, input logic last);
      src_q[s].push_back({last, d});
   endtask

   task automatic expect_xfer(input int s, input logic [7:0] d);
      exp_q.push_back({3'(s), d});
   endtask

   task automatic flush_all();
      for (int i = 0; i < N; i++) src_q[i].delete();
      exp_q.delete();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      flush_all();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      bit empty;
      ok = 1'b0;
      for (int t = 0; t < budget && !ok; t++) begin
         @(posedge clk);
         #2;
         empty = (exp_q.size() == 0);
         for (int i = 0; i < N; i++) if (src_q[i].size() != 0) empty = 1'b0;
         if (empty && busy === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if ({busy, grant, stall_cnt, bus.tx_require, bus.tx_data, bus.src_valid} !==
          {1'b0, 2'd0, 16'h0000, 1'b0, 8'h00, 4'h0}) begin
         miscompares++;
         $display("FAIL reset_values: busy=%b grant=%0d stall=%h txreq=%b txd=%h sv=%b, required all zero",
                  busy, grant, stall_cnt, bus.tx_require, bus.tx_data, bus.src_valid);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      bit ok;
      int base;
      ack_gap = 10;
      base = xfer_cnt;
      send(0, 8'h4F, 1'b0); send(0, 8'h4B, 1'b0); send(0, 8'h0D, 1'b0); send(0, 8'h0A, 1'b1);
      expect_xfer(0, 8'h4F); expect_xfer(0, 8'h4B); expect_xfer(0, 8'h0D); expect_xfer(0, 8'h0A);
      wait_drain(200, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL single_timeout: drained=%b, required 1", ok); end
      vectors++;
      if (xfer_cnt - base != 4) begin
         miscompares++;
         $display("FAIL single_count: transfers=%0d, required 4", xfer_cnt - base);
      end
      // Stray acknowledges while idle must not start or end anything.
      tx_force = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      tx_force = 1'b0;
      vectors++;
      if (busy !== 1'b0 || xfer_cnt - base != 4) begin
         miscompares++;
         $display("FAIL idle_ack: busy=%b transfers=%0d, required 0 and 4", busy, xfer_cnt - base);
      end
   endtask

   task automatic test_contention();
      bit ok;
      apply_reset();
      ack_gap = 2;
      for (int s = 0; s < 3; s++) begin
         for (int b = 0; b < 3; b++) send(s, 8'(16*(s+1) + b), b == 2);
      end
      for (int s = 0; s < 3; s++) begin
         for (int b = 0; b < 3; b++) expect_xfer(s, 8'(16*(s+1) + b));
      end
      wait_drain(200, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL contention_timeout: drained=%b, required 1", ok); end
   endtask

   task automatic test_fairness();
      bit ok;
      int base;
      ack_gap = 3;
      base = xfer_cnt;
      send(3, 8'hA0, 1'b1); send(3, 8'hA1, 1'b1); send(3, 8'hA2, 1'b1);
      send(1, 8'hB0, 1'b1);
      expect_xfer(3, 8'hA0); expect_xfer(1, 8'hB0); expect_xfer(3, 8'hA1); expect_xfer(3, 8'hA2);
      for (int t = 0; t < 100 && xfer_cnt < base + 2; t++) begin
         @(posedge clk);
         #2;
      end
      vectors++;
      if (dut.rr_ptr_reg !== 2'd2) begin
         miscompares++;
         $display("FAIL fairness_ptr: rr_ptr=%0d, required 2", dut.rr_ptr_reg);
      end
      wait_drain(200, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL fairness_timeout: drained=%b, required 1", ok); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int base;
      ack_gap = 3;
      base = xfer_cnt;
      send(1, 8'hC0, 1'b0); send(1, 8'hC1, 1'b0); send(1, 8'hC2, 1'b0);
      send(1, 8'hC3, 1'b0); send(1, 8'hC4, 1'b1);
      expect_xfer(1, 8'hC0);
      for (int t = 0; t < 100 && xfer_cnt < base + 1; t++) begin
         @(posedge clk);
         #2;
      end
      vectors++;
      if (busy !== 1'b1 || grant !== 2'd1 || bus.tx_require !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_msg: busy=%b grant=%0d txreq=%b, required 1/1/1", busy, grant, bus.tx_require);
      end
      rst_n = 1'b0;
      flush_all();
      #1;
      vectors++;
      if ({busy, grant, stall_cnt, bus.tx_require, bus.tx_data, bus.src_valid} !==
          {1'b0, 2'd0, 16'h0000, 1'b0, 8'h00, 4'h0}) begin
         miscompares++;
         $display("FAIL async_reset: busy=%b grant=%0d stall=%h txreq=%b txd=%h sv=%b, required all zero",
                  busy, grant, stall_cnt, bus.tx_require, bus.tx_data, bus.src_valid);
      end
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      send(0, 8'hD0, 1'b0); send(0, 8'hD1, 1'b1);
      send(1, 8'hE0, 1'b1);
      expect_xfer(0, 8'hD0); expect_xfer(0, 8'hD1); expect_xfer(1, 8'hE0);
      wait_drain(200, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL reset_resume_timeout: drained=%b, required 1", ok); end
   endtask

   task automatic test_stall();
      bit ok;
      int base, t0, t1;
      ack_gap = 1;
      base = xfer_cnt;
      send(2, 8'h5A, 1'b0);
      send(0, 8'h5B, 1'b1);
      expect_xfer(2, 8'h5A); expect_xfer(0, 8'h5B);
      for (int t = 0; t < 100 && xfer_cnt < base + 1; t++) begin
         @(posedge clk);
         #2;
      end
      t0 = xfer_cyc;
      t1 = -1;
      for (int t = 0; t < 100 && t1 < 0; t++) begin
         @(posedge clk);
         #2;
         if (busy === 1'b0) t1 = cyc;
      end
      vectors++;
      if (t1 - t0 != TMO + 1) begin
         miscompares++;
         $display("FAIL stall_latency: revoked %0d edges after ack, required %0d", t1 - t0, TMO + 1);
      end
      vectors++;
      if (stall_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL stall_count: stall_cnt=%h, required 0001", stall_cnt);
      end
      wait_drain(200, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL stall_timeout: drained=%b, required 1", ok); end
   endtask

   task automatic test_saturation();
      bit ok;
      logic [16:0] want;
      ack_gap = 1;
      force dut.stall_cnt_reg = 16'hFFFD;
      @(posedge clk);
      #2;
      release dut.stall_cnt_reg;
      @(posedge clk);
      #2;
      vectors++;
      if (stall_cnt !== 16'hFFFD) begin
         miscompares++;
         $display("FAIL sat_preload: stall_cnt=%h, required FFFD", stall_cnt);
      end
      for (int n = 1; n <= 3; n++) begin
         send(1, 8'(8'h60 + n), 1'b0);
         expect_xfer(1, 8'(8'h60 + n));
         wait_drain(100, ok);
         want = 17'h0FFFD + 17'(n);
         if (want > 17'h0FFFF) want = 17'h0FFFF;
         vectors++;
         if (!ok || stall_cnt !== want[15:0]) begin
            miscompares++;
            $display("FAIL saturation_%0d: drained=%b stall_cnt=%h, required %h", n, ok, stall_cnt, want[15:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_reset_mid();
      test_stall();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
